// File: rtl/if_id_dump_tx.sv
// Streams a frozen IF/ID latch snapshot to the UART TX as HEADER, data bytes LSB-first, XOR checksum.
// One byte per start/done handshake; a synchronous reset aborts any frame in flight.
module if_id_dump_tx #(
  parameter int                  IF_ID_SIZE = 40,
  parameter int                  NB_BYTE    = 8,
  parameter logic [NB_BYTE-1:0]  HEADER     = 8'h1D
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_start,
  input  logic [IF_ID_SIZE-1:0] i_IF_ID_data,
  input  logic                  i_tx_done,
  output logic                  o_tx_start,
  output logic [NB_BYTE-1:0]    o_tx_data,
  output logic                  o_busy,
  output logic                  o_done
);

  localparam int NB_DATA  = (IF_ID_SIZE + NB_BYTE - 1) / NB_BYTE;
  localparam int PAD_W    = NB_DATA * NB_BYTE;
  localparam int NB_FRAME = NB_DATA + 2;
  localparam int IDX_W    = $clog2(NB_FRAME);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NB_FRAME - 1);

  typedef enum logic [1:0] {IDLE, SEND, WAIT, DONE} state_t;

  state_t               state_q, state_d;
  logic [PAD_W-1:0]     snap_q, snap_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [NB_BYTE-1:0]   chk_q, chk_d;
  logic [NB_BYTE-1:0]   txData_q, txData_d;
  logic [PAD_W-1:0]     captureWord;
  logic [IDX_W-1:0]     nextIdx;
  logic [NB_BYTE-1:0]   dataByte;

  // Frame index: 0 is the header, 1..NB_DATA the data bytes, LAST_IDX the checksum.
  always_comb begin
    state_d   = state_q;
    snap_d    = snap_q;
    idx_d     = idx_q;
    chk_d     = chk_q;
    txData_d  = txData_q;
    captureWord = '0;
    captureWord[IF_ID_SIZE-1:0] = i_IF_ID_data;
    nextIdx   = idx_q + IDX_W'(1);
    dataByte  = '0;
    for (int i = 0; i < NB_DATA; i++) begin
      if (nextIdx == IDX_W'(i + 1)) dataByte = snap_q[i*NB_BYTE +: NB_BYTE];
    end

    case (state_q)
      IDLE: begin
        if (i_start) begin
          state_d  = SEND;
          snap_d   = captureWord;
          idx_d    = '0;
          chk_d    = '0;
          txData_d = HEADER;
        end
      end
      SEND: state_d = WAIT;
      WAIT: begin
        if (i_tx_done) begin
          if (idx_q == LAST_IDX) begin
            state_d = DONE;
          end else begin
            state_d = SEND;
            idx_d   = nextIdx;
            // The checksum is complete by the time the last index is reached.
            if (nextIdx == LAST_IDX) begin
              txData_d = chk_q;
            end else begin
              txData_d = dataByte;
              chk_d    = chk_q ^ dataByte;
            end
          end
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q  <= IDLE;
      snap_q   <= '0;
      idx_q    <= '0;
      chk_q    <= '0;
      txData_q <= '0;
    end else begin
      state_q  <= state_d;
      snap_q   <= snap_d;
      idx_q    <= idx_d;
      chk_q    <= chk_d;
      txData_q <= txData_d;
    end
  end

  assign o_tx_start = (state_q == SEND);
  assign o_tx_data  = txData_q;
  assign o_busy     = (state_q != IDLE);
  assign o_done     = (state_q == DONE);

endmodule

// File: tb/tb_if_id_dump_tx.sv
// Self-checking bench for if_id_dump_tx: table of frames (fixed and random) against a byte-list model,
// plus hand-written sequences for snapshot freeze, ignored inputs and mid-frame reset.
module tb_if_id_dump_tx;

  logic        i_clk = 1'b0;
  logic        i_reset;
  logic        i_start;
  logic [39:0] i_IF_ID_data;
  logic        i_tx_done;
  logic        o_tx_start;
  logic [7:0]  o_tx_data;
  logic        o_busy;
  logic        o_done;

  logic        respDone  = 1'b0;
  logic        forceDone = 1'b0;
  int          respLatency = 1;
  int          pending = 0;

  logic [7:0]  gotQ[$];
  int          startCnt = 0;
  int          doneCnt  = 0;
  int          b2bCnt   = 0;
  logic        prevStart = 1'b0;

  int          total = 0;
  int          bad   = 0;

  typedef struct packed {
    logic [39:0] data;
    logic [2:0]  lat;
    logic [55:0] exp;
  } vec_t;

  vec_t vecs[9];

  assign i_tx_done = respDone | forceDone;

  if_id_dump_tx dut (
    .i_clk        (i_clk),
    .i_reset      (i_reset),
    .i_start      (i_start),
    .i_IF_ID_data (i_IF_ID_data),
    .i_tx_done    (i_tx_done),
    .o_tx_start   (o_tx_start),
    .o_tx_data    (o_tx_data),
    .o_busy       (o_busy),
    .o_done       (o_done)
  );

  always #5 i_clk = ~i_clk;

  // UART TX stand-in: pulses done respLatency cycles after each start.
  always @(negedge i_clk) begin
    respDone = 1'b0;
    if (o_tx_start) begin
      pending = respLatency;
    end else if (pending > 0) begin
      pending = pending - 1;
      if (pending == 0) respDone = 1'b1;
    end
  end

  // Observes everything the UART TX would see.
  always @(negedge i_clk) begin
    if (o_tx_start) begin
      gotQ.push_back(o_tx_data);
      startCnt = startCnt + 1;
      if (prevStart) b2bCnt = b2bCnt + 1;
    end
    if (o_done) doneCnt = doneCnt + 1;
    prevStart = o_tx_start;
  end

  // Frame as a list of bytes: header, data bytes low first, then XOR of the data bytes.
  function automatic logic [55:0] modelFrame(input logic [39:0] d);
    logic [7:0] bytes[$];
    logic [7:0] chk;
    logic [55:0] f;
    chk = 8'h00;
    bytes.push_back(8'h1D);
    for (int k = 0; k < 5; k++) begin
      bytes.push_back(8'((d >> (8 * k)) & 40'hFF));
      chk = chk ^ bytes[k + 1];
    end
    bytes.push_back(chk);
    f = '0;
    for (int k = 0; k < 7; k++) f[8*k +: 8] = bytes[k];
    return f;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    total = total + 1;
    if (actual !== expected) begin
      bad = bad + 1;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) @(negedge i_clk);
  endtask

  // Called at a negedge; returns at the negedge of the first IDLE cycle after the frame.
  task automatic applyStimulus(input string name, input logic [39:0] data, input int lat,
                               input bit freeze, input bit poke,
                               output logic [55:0] got, output int cycles, output bit timedOut);
    gotQ.delete();
    startCnt = 0;
    doneCnt  = 0;
    respLatency = lat;
    i_IF_ID_data = data;
    i_start = 1'b1;
    cycles = 0;
    timedOut = 1'b0;
    got = '0;
    forever begin
      @(negedge i_clk);
      i_start = 1'b0;
      cycles = cycles + 1;
      if (cycles == 1) begin
        checkOutput({name, "_hdr_start"}, 64'(o_tx_start), 64'd1);
        checkOutput({name, "_hdr_data"}, 64'(o_tx_data), 64'h1D);
        checkOutput({name, "_hdr_busy"}, 64'(o_busy), 64'd1);
      end
      if (freeze && gotQ.size() >= 1) i_IF_ID_data = 40'hFF_FFFF_FFFF;
      if (poke) i_start = o_busy && !o_tx_start;
      if (o_done) break;
      if (cycles >= 300) begin
        timedOut = 1'b1;
        break;
      end
    end
    @(negedge i_clk);
    i_start = 1'b0;
    for (int k = 0; k < 7 && k < gotQ.size(); k++) got[8*k +: 8] = gotQ[k];
  endtask

  task automatic runAndCheck(input string name, input logic [39:0] data, input int lat,
                             input bit freeze, input bit poke, input logic [55:0] expFrame);
    logic [55:0] got;
    int cycles;
    bit timedOut;
    applyStimulus(name, data, lat, freeze, poke, got, cycles, timedOut);
    checkOutput({name, "_timeout"}, 64'(timedOut), 64'd0);
    checkOutput({name, "_frame"}, 64'(got), 64'(expFrame));
    checkOutput({name, "_starts"}, 64'(startCnt), 64'd7);
    checkOutput({name, "_dones"}, 64'(doneCnt), 64'd1);
    checkOutput({name, "_cycles"}, 64'(cycles), 64'(8 + 7 * lat));
    checkOutput({name, "_busy_after"}, 64'(o_busy), 64'd0);
  endtask

  initial begin
    i_reset = 1'b1;
    i_start = 1'b0;
    i_IF_ID_data = '0;

    vecs[0] = '{data: 40'hAB_CDEF_0123, lat: 3'd3, exp: {8'hAB, 40'hAB_CDEF_0123, 8'h1D}};
    vecs[1] = '{data: 40'h00_0000_0000, lat: 3'd1, exp: {8'h00, 40'h00_0000_0000, 8'h1D}};
    vecs[2] = '{data: 40'h01_0000_0002, lat: 3'd1, exp: {8'h03, 40'h01_0000_0002, 8'h1D}};
    for (int v = 3; v < 9; v++) begin
      vecs[v].data = {8'($urandom), 32'($urandom)};
      vecs[v].lat  = 3'($urandom_range(1, 5));
      vecs[v].exp  = modelFrame(vecs[v].data);
    end

    tick(3);
    checkOutput("reset_tx_start", 64'(o_tx_start), 64'd0);
    checkOutput("reset_tx_data", 64'(o_tx_data), 64'd0);
    checkOutput("reset_busy", 64'(o_busy), 64'd0);
    checkOutput("reset_done", 64'(o_done), 64'd0);

    // Start coinciding with reset must be dropped.
    i_start = 1'b1;
    i_IF_ID_data = 40'h12_3456_789A;
    tick(1);
    i_reset = 1'b0;
    i_start = 1'b0;
    tick(2);
    checkOutput("reset_vs_start_busy", 64'(o_busy), 64'd0);
    checkOutput("reset_vs_start_nostart", 64'(startCnt), 64'd0);

    // Table frames run back to back: each i_start lands in the cycle o_busy falls.
    for (int v = 0; v < 9; v++) begin
      runAndCheck($sformatf("vec%0d", v), vecs[v].data, int'(vecs[v].lat), 1'b0, 1'b0, vecs[v].exp);
    end
    checkOutput("no_back_to_back_start", 64'(b2bCnt), 64'd0);

    tick(2);
    runAndCheck("freeze", 40'hAB_CDEF_0123, 2, 1'b1, 1'b0, {8'hAB, 40'hAB_CDEF_0123, 8'h1D});

    tick(2);
    runAndCheck("poke_start", 40'h5A_C3F0_0F11, 2, 1'b0, 1'b1, modelFrame(40'h5A_C3F0_0F11));
    startCnt = 0;
    tick(6);
    checkOutput("poke_no_extra_frame", 64'(startCnt), 64'd0);
    forceDone = 1'b1;
    tick(3);
    forceDone = 1'b0;
    tick(4);
    checkOutput("idle_done_ignored_starts", 64'(startCnt), 64'd0);
    checkOutput("idle_done_ignored_busy", 64'(o_busy), 64'd0);

    // Reset right after the third byte is handed to the TX.
    gotQ.delete();
    startCnt = 0;
    doneCnt = 0;
    respLatency = 3;
    i_IF_ID_data = 40'hAB_CDEF_0123;
    i_start = 1'b1;
    for (int c = 0; c < 100; c++) begin
      @(negedge i_clk);
      i_start = 1'b0;
      if (gotQ.size() >= 3) break;
    end
    checkOutput("midreset_reached_byte3", 64'(gotQ.size()), 64'd3);
    i_reset = 1'b1;
    tick(1);
    i_reset = 1'b0;
    checkOutput("midreset_tx_start", 64'(o_tx_start), 64'd0);
    checkOutput("midreset_tx_data", 64'(o_tx_data), 64'd0);
    checkOutput("midreset_busy", 64'(o_busy), 64'd0);
    checkOutput("midreset_done", 64'(o_done), 64'd0);
    tick(10);
    checkOutput("midreset_no_more_starts", 64'(startCnt), 64'd3);
    checkOutput("midreset_no_done", 64'(doneCnt), 64'd0);
    runAndCheck("after_reset", 40'h00_0000_0000, 1, 1'b0, 1'b0, {8'h00, 40'h0, 8'h1D});

    checkOutput("final_no_back_to_back", 64'(b2bCnt), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
